// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'hBFC00000;
  localparam logic [31:0] INSTR_BYTES       = 32'd4;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem read, a single held
// instruction for decode, and redirect handling that drops in-flight data.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        misalign_err
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  fetch_pc_reg, fetch_pc_next;
  logic [31:0]  addr_reg, addr_next;
  logic         valid_reg, valid_next;
  logic [31:0]  instr_reg, instr_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  pc4_reg, pc4_next;
  logic         mis_reg, mis_next;
  logic [31:0]  target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_VEC;
      addr_reg     <= RESET_VEC;
      valid_reg    <= 1'b0;
      instr_reg    <= '0;
      pc_reg       <= '0;
      pc4_reg      <= '0;
      mis_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      addr_reg     <= addr_next;
      valid_reg    <= valid_next;
      instr_reg    <= instr_next;
      pc_reg       <= pc_next;
      pc4_reg      <= pc4_next;
      mis_reg      <= mis_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    addr_next     = addr_reg;
    valid_next    = valid_reg;
    instr_next    = instr_reg;
    pc_next       = pc_reg;
    pc4_next      = pc4_reg;
    target        = align_word(redirect_pc);
    mis_next      = redirect_valid && (redirect_pc[1:0] != 2'b00);
    imem_req      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (redirect_valid) fetch_pc_next = target;
        state_next = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          fetch_pc_next = target;
          state_next    = imem_ack ? FETCH : DROP;
        end else if (imem_ack) begin
          valid_next    = 1'b1;
          instr_next    = imem_rdata;
          pc_next       = fetch_pc_reg;
          pc4_next      = fetch_pc_reg + INSTR_BYTES;
          fetch_pc_next = fetch_pc_reg + INSTR_BYTES;
          state_next    = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          valid_next    = 1'b0;
          fetch_pc_next = target;
          state_next    = FETCH;
        end else if (!stall_i) begin
          valid_next = 1'b0;
          state_next = FETCH;
        end
      end
      DROP: begin
        // Old request stays on the bus until acked; its data is discarded.
        imem_req = 1'b1;
        if (redirect_valid) fetch_pc_next = target;
        if (imem_ack) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase

    // The bus address only moves when a new request is launched.
    if (state_next == FETCH) addr_next = fetch_pc_next;
  end

  assign imem_addr    = addr_reg;
  assign if_valid     = valid_reg;
  assign if_instr     = instr_reg;
  assign if_pc        = pc_reg;
  assign if_pc4       = pc4_reg;
  assign misalign_err = mis_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, reset-abandon
// sequence and randomized traffic against a transaction-level model.
module tb_fetch_ctrl;

  localparam logic [31:0] R = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        misalign_err;

  fetch_ctrl #(.RESET_VEC(R)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] tgt;
    logic        ack;
    logic        stall;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  vec_t vec_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: a request may be outstanding, possibly doomed.
  bit          m_started, m_busy, m_discard, m_have, m_mis;
  logic [31:0] m_pc, m_req_addr, m_instr, m_ipc;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", nm, act, want);
    end
  endtask

  task automatic add(input logic redir, input logic [31:0] tgt, input logic ack,
                     input logic stall, input logic [31:0] rdata, input logic e_req,
                     input logic [31:0] e_addr, input logic e_valid,
                     input logic [31:0] e_instr, input logic [31:0] e_pc, input logic e_mis);
    vec_t v;
    v = '{redir, tgt, ack, stall, rdata, e_req, e_addr, e_valid, e_instr, e_pc, e_mis};
    vec_q.push_back(v);
  endtask

  task automatic drive(input logic redir, input logic [31:0] tgt, input logic ack,
                       input logic stall, input logic [31:0] rdata);
    redirect_valid = redir;
    redirect_pc    = tgt;
    imem_ack       = ack;
    stall_i        = stall;
    imem_rdata     = rdata;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", imem_req, 0);
    check("rst_valid", if_valid, 0);
    check("rst_instr", if_instr, 0);
    check("rst_pc", if_pc, 0);
    check("rst_pc4", if_pc4, 0);
    check("rst_mis", misalign_err, 0);
    rst = 1'b0;
  endtask

  task automatic model_reset();
    m_started = 0; m_busy = 0; m_discard = 0; m_have = 0; m_mis = 0;
    m_pc = R; m_req_addr = R; m_instr = '0; m_ipc = '0;
  endtask

  task automatic model_step();
    logic [31:0] t;
    t = {redirect_pc[31:2], 2'b00};
    m_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
    if (!m_started) begin
      m_started = 1;
      if (redirect_valid) m_pc = t;
      m_busy = 1;
      m_req_addr = m_pc;
    end else if (m_busy) begin
      if (imem_ack) begin
        if (m_discard || redirect_valid) begin
          if (redirect_valid) m_pc = t;
          m_discard = 0;
          m_req_addr = m_pc;
        end else begin
          m_have = 1; m_instr = imem_rdata; m_ipc = m_req_addr;
          m_pc = m_req_addr + 32'd4;
          m_busy = 0;
        end
      end else if (redirect_valid) begin
        m_pc = t;
        m_discard = 1;
      end
    end else if (redirect_valid || !stall_i) begin
      m_have = 0;
      if (redirect_valid) m_pc = t;
      m_busy = 1;
      m_req_addr = m_pc;
    end
  endtask

  initial begin
    // redir tgt ack stall rdata | req addr valid instr pc mis
    add(0, 0, 0, 0, 0,                    1, R,        0, 0, 0, 0);
    add(0, 0, 0, 0, 0,                    1, R,        0, 0, 0, 0);
    add(0, 0, 0, 0, 0,                    1, R,        0, 0, 0, 0);
    add(0, 0, 1, 0, 32'h11111111,         0, R,        1, 32'h11111111, R, 0);
    add(0, 0, 0, 0, 0,                    1, R+4,      0, 0, 0, 0);
    add(0, 0, 1, 1, 32'h22222222,         0, R+4,      1, 32'h22222222, R+4, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, (i == 2), 1, 32'hDEADBEEF, 0, R+4,     1, 32'h22222222, R+4, 0);
    add(0, 0, 0, 0, 0,                    1, R+8,      0, 0, 0, 0);
    add(1, 32'h80000100, 0, 0, 0,         1, R+8,      0, 0, 0, 0);
    add(0, 0, 0, 0, 0,                    1, R+8,      0, 0, 0, 0);
    add(0, 0, 0, 0, 0,                    1, R+8,      0, 0, 0, 0);
    add(0, 0, 1, 0, 32'h33333333,         1, 32'h80000100, 0, 0, 0, 0);
    add(1, 32'h00001000, 1, 0, 32'h77777777, 1, 32'h00001000, 0, 0, 0, 0);
    add(1, 32'h00000102, 0, 0, 0,         1, 32'h00001000, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0,                    1, 32'h00001000, 0, 0, 0, 0);
    add(0, 0, 1, 0, 32'h88888888,         1, 32'h00000100, 0, 0, 0, 0);
    add(0, 0, 1, 1, 32'h55555555,         0, 32'h00000100, 1, 32'h55555555, 32'h100, 0);
    add(1, 32'hFFFFFFFC, 0, 1, 0,         1, 32'hFFFFFFFC, 0, 0, 0, 0);
    add(0, 0, 1, 0, 32'h66666666,         0, 32'hFFFFFFFC, 1, 32'h66666666, 32'hFFFFFFFC, 0);
    add(0, 0, 0, 0, 0,                    1, 32'h00000000, 0, 0, 0, 0);
    add(0, 0, 1, 1, 32'h99999999,         0, 32'h00000000, 1, 32'h99999999, 32'h0, 0);
    add(1, 32'h00000203, 0, 1, 0,         1, 32'h00000200, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0,                    1, 32'h00000200, 0, 0, 0, 0);

    do_reset();
    foreach (vec_q[i]) begin
      drive(vec_q[i].redir, vec_q[i].tgt, vec_q[i].ack, vec_q[i].stall, vec_q[i].rdata);
      @(posedge clk); #1;
      check($sformatf("v%0d_req", i), imem_req, vec_q[i].e_req);
      check($sformatf("v%0d_addr", i), imem_addr, vec_q[i].e_addr);
      check($sformatf("v%0d_valid", i), if_valid, vec_q[i].e_valid);
      check($sformatf("v%0d_mis", i), misalign_err, vec_q[i].e_mis);
      if (vec_q[i].e_valid) begin
        check($sformatf("v%0d_instr", i), if_instr, vec_q[i].e_instr);
        check($sformatf("v%0d_pc", i), if_pc, vec_q[i].e_pc);
        check($sformatf("v%0d_pc4", i), if_pc4, vec_q[i].e_pc + 32'd4);
      end
      $display("vec %0d: req=%0b addr=%08h valid=%0b pc=%08h mis=%0b",
               i, imem_req, imem_addr, if_valid, if_pc, misalign_err);
    end

    // Reset in the middle of an outstanding fetch; late ack must be ignored.
    do_reset();
    @(posedge clk); #1;
    check("mid_req_up", imem_req, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("mid_req_drop", imem_req, 0);
    check("mid_valid", if_valid, 0);
    drive(0, 0, 1, 0, 32'hAAAAAAAA);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_refetch_req", imem_req, 1);
    check("mid_refetch_addr", imem_addr, R);
    check("mid_ack_ignored", if_valid, 0);
    drive(0, 0, 1, 1, 32'hBBBBBBBB);
    @(posedge clk); #1;
    check("mid_fetch_valid", if_valid, 1);
    check("mid_fetch_pc", if_pc, R);
    check("mid_fetch_instr", if_instr, 32'hBBBBBBBB);
    $display("reset-abandon sequence: pc=%08h instr=%08h", if_pc, if_instr);

    // Randomized traffic against the transaction model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) t = 32'hFFFFFFFC;
      drive(($urandom_range(0, 7) == 0), t, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom);
      @(posedge clk);
      model_step();
      #1;
      check("rnd_req", imem_req, m_busy);
      if (m_busy) check("rnd_addr", imem_addr, m_req_addr);
      check("rnd_valid", if_valid, m_have);
      check("rnd_mis", misalign_err, m_mis);
      if (m_have) begin
        check("rnd_instr", if_instr, m_instr);
        check("rnd_pc", if_pc, m_ipc);
        check("rnd_pc4", if_pc4, m_ipc + 32'd4);
      end
      if (m_have && !m_busy && redirect_valid == 1'b0 && imem_ack && !stall_i)
        $display("rnd cycle %0d: instr %08h at %08h", c, if_instr, if_pc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
